wb_lsu_master: RTL and testbench
================================

WB_LSU_MASTER -- requirements
Module: wb_lsu_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: bus cycles without ack before abort (macro-enabled only).
REQ-002 SHALL have parameter RD_DELAY, default 1: cycles after ack before dat_i holds valid read data; legal values 0 or 1.
REQ-003 clk_i  in  1  clock.
REQ-004 rst_ni  in  1  reset; asynchronous, active-low.
REQ-005 req_valid_i  in  1  core load/store request.
REQ-006 req_ready_o  out  1  request accepted this cycle when high with req_valid_i.
REQ-007 req_we_i  in  1  1=store, 0=load.
REQ-008 req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 req_unsigned_i  in  1  load zero-extends when high, sign-extends when low.
REQ-010 req_addr_i  in  32  byte address.
REQ-011 req_wdata_i  in  32  store data, right-aligned.
REQ-012 rsp_valid_o  out  1  one-cycle completion pulse.
REQ-013 rsp_rdata_o  out  32  extended load data; 0 for stores and errors.
REQ-014 rsp_err_o  out  1  misaligned, illegal size or timeout; valid with rsp_valid_o.
REQ-015 cyc_o, stb_o  out  1 each  Wishbone cycle and strobe, always equal.
REQ-016 adr_o  out  32  word address; bits [1:0] forced to 0.
REQ-017 we_o  out  1  write enable.
REQ-018 sel_o  out  4  byte-lane select.
REQ-019 dat_o  out  32  write data, lane-replicated.
REQ-020 dat_i  in  32  read data.
REQ-021 ack_i  in  1  slave acknowledge; combinational from stb is legal.

Function
REQ-022 SHALL implement FSM IDLE, BUS, RDWAIT, RESP; req_ready_o SHALL be high only in IDLE.
REQ-023 IDLE: on accepted request, latch all req_* fields; aligned and legal -> BUS; otherwise -> RESP with err=1 and no bus cycle.
REQ-024 Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
REQ-025 BUS: cyc_o/stb_o/adr_o/we_o/sel_o/dat_o SHALL be held stable until ack_i is sampled high; on that edge cyc_o/stb_o SHALL drop.
REQ-026 On ack: store -> RESP; load with RD_DELAY=0 -> capture dat_i on the ack edge, go to RESP; load with RD_DELAY=1 -> RDWAIT, capture dat_i at the next edge, go to RESP.
REQ-027 RESP: rsp_valid_o high for exactly one cycle, then IDLE; a new request is accepted no earlier than the following cycle.
REQ-028 Latency, zero-wait slave, accept at edge N: store rsp_valid_o in cycle N+2; load with RD_DELAY=1 in cycle N+3.
REQ-029 sel_o: byte 0001<<addr[1:0]; half 0011 or 1100 by addr[1]; word 1111.
REQ-030 dat_o: byte wdata[7:0] x4; half wdata[15:0] x2; word wdata.
REQ-031 Load: shift dat_i right by 8*addr[1:0], then extend the 8/16 bits per req_unsigned_i.
REQ-032 ack_i outside BUS SHALL be ignored.

Reset
REQ-033 rst_ni low SHALL immediately force IDLE, clear cyc_o/stb_o/we_o/rsp_valid_o/rsp_err_o and zero sel_o/adr_o/dat_o/rsp_rdata_o, including mid-cycle; the in-flight request is dropped without a response.

Configuration
REQ-034 WB_LSU_TIMEOUT_EN defined: count BUS cycles; at TIMEOUT_CYCLES without ack, drop cyc_o/stb_o and go to RESP with err=1, rdata=0. Undefined: no counter, BUS waits indefinitely.

Structure
REQ-035 Package lsu_pkg SHALL hold the size enum (SZ_B/SZ_H/SZ_W) and the FSM state enum.
REQ-036 Sub-module lsu_lane_align SHALL do combinational sel/dat_o steering and load extraction/extension.

Verification
REQ-037 SB 0xA5 at 0x103 -> sel_o=1000, dat_o=0xA5A5A5A5, adr_o=0x100, rsp_valid_o in N+2, err=0.
REQ-038 Memory word 0x80FF7F01; LB at 0x102 -> 0xFFFFFFFF; LBU -> 0x000000FF; LH at 0x102 -> 0xFFFF80FF (RD_DELAY=1).
REQ-039 LW at 0x102 -> no cyc_o, rsp_err_o=1, rsp_rdata_o=0; req_size_i=11 behaves the same.
REQ-040 ack_i delayed 5 cycles -> all bus outputs stable for those cycles; one rsp_valid_o pulse.
REQ-041 WB_LSU_TIMEOUT_EN, TIMEOUT_CYCLES=16, ack never -> cyc_o drops after 16 cycles, rsp_err_o=1.
REQ-042 rst_ni low mid-BUS -> cyc_o low immediately, no rsp_valid_o; next request completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and request-legality helper for the Wishbone load/store master.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } lsu_size_e;

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StRdWait,
        StResp
    } lsu_state_e;

    // High when the request must be rejected without touching the bus.
    function automatic logic lsu_bad_req(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = addr_lo[0];
            SZ_W:    bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension for loads.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        uns_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    always_comb begin
        sel_o   = 4'b0000;
        wdata_o = wdata_i;
        case (size_i)
            SZ_B: begin
                sel_o   = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SZ_H: begin
                sel_o   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            SZ_W: begin
                sel_o   = 4'b1111;
                wdata_o = wdata_i;
            end
            default: begin
                sel_o   = 4'b0000;
                wdata_o = wdata_i;
            end
        endcase
    end

    always_comb begin
        shifted = rdata_i >> {addr_lo_i, 3'b000};
        rdata_o = shifted;
        case (size_i)
            SZ_B:    rdata_o = uns_i ? {24'h0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H:    rdata_o = uns_i ? {16'h0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
            default: rdata_o = shifted;
        endcase
    end

endmodule

// File: rtl/wb_lsu_master.sv
// Single-outstanding Wishbone classic master for core loads/stores.
// Define WB_LSU_TIMEOUT_EN to abort bus cycles that never see ack_i.
module wb_lsu_master
    import lsu_pkg::*;
#(
`ifdef WB_LSU_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 16,
`endif
    parameter int unsigned RD_DELAY = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic [31:0] adr_o,
    output logic        we_o,
    output logic [3:0]  sel_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i
);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
`ifdef WB_LSU_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;
`endif

    logic [3:0]  lane_sel;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;
    logic        bus_active;

    lsu_lane_align u_lane_align (
        .size_i    (size_q),
        .addr_lo_i (addr_q[1:0]),
        .uns_i     (uns_q),
        .wdata_i   (wdata_q),
        .rdata_i   (dat_i),
        .sel_o     (lane_sel),
        .wdata_o   (lane_wdata),
        .rdata_o   (lane_rdata)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef WB_LSU_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    size_d  = req_size_i;
                    uns_d   = req_unsigned_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    rdata_d = 32'h0;
                    err_d   = lsu_bad_req(req_size_i, req_addr_i[1:0]);
                    state_d = err_d ? StResp : StBus;
`ifdef WB_LSU_TIMEOUT_EN
                    tmo_d   = 32'h0;
`endif
                end
            end
            StBus: begin
                if (ack_i) begin
                    if (we_q) begin
                        state_d = StResp;
                    end else if (RD_DELAY == 0) begin
                        rdata_d = lane_rdata;
                        state_d = StResp;
                    end else begin
                        state_d = StRdWait;
                    end
                end
`ifdef WB_LSU_TIMEOUT_EN
                else if (tmo_q == TIMEOUT_CYCLES - 1) begin
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                    state_d = StResp;
                end else begin
                    tmo_d = tmo_q + 32'h1;
                end
`endif
            end
            StRdWait: begin
                rdata_d = lane_rdata;
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
`ifdef WB_LSU_TIMEOUT_EN
            tmo_q   <= 32'h0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef WB_LSU_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    // Bus and response outputs are gated by state so reset clears them without waiting for a clock.
    always_comb begin
        bus_active  = (state_q == StBus);
        req_ready_o = (state_q == StIdle);
        cyc_o       = bus_active;
        stb_o       = bus_active;
        we_o        = bus_active & we_q;
        adr_o       = bus_active ? {addr_q[31:2], 2'b00} : 32'h0;
        sel_o       = bus_active ? lane_sel : 4'b0000;
        dat_o       = bus_active ? lane_wdata : 32'h0;
        rsp_valid_o = (state_q == StResp);
        rsp_err_o   = rsp_valid_o & err_q;
        rsp_rdata_o = rsp_valid_o ? rdata_q : 32'h0;
    end

endmodule

// File: tb/tb_wb_lsu_master.sv
// Directed self-checking bench for wb_lsu_master with a bench-driven Wishbone slave.
module tb_wb_lsu_master;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        cyc_o;
    logic        stb_o;
    logic [31:0] adr_o;
    logic        we_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack_i;

    logic ack_auto;
    logic ack_man;
    int   checks;
    int   failures;

    // Zero-wait slave when ack_auto is set; otherwise ack is steered by hand.
    assign ack_i = (ack_auto & stb_o & cyc_o) | ack_man;

    always #5 clk_i = ~clk_i;

    wb_lsu_master #(.RD_DELAY(1)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .cyc_o          (cyc_o),
        .stb_o          (stb_o),
        .adr_o          (adr_o),
        .we_o           (we_o),
        .sel_o          (sel_o),
        .dat_o          (dat_o),
        .dat_i          (dat_i),
        .ack_i          (ack_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request; lat is cycles from the presenting cycle to rsp_valid_o (-1 if none).
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output logic saw_cyc, output logic [3:0] sel_seen,
                          output logic [31:0] dat_seen, output logic [31:0] adr_seen);
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
        rdata = 32'h0; err = 1'b0; lat = -1; saw_cyc = 1'b0;
        sel_seen = 4'h0; dat_seen = 32'h0; adr_seen = 32'h0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk_i); #1;
            req_valid_i = 1'b0;
            if (cyc_o && !saw_cyc) begin
                saw_cyc  = 1'b1;
                sel_seen = sel_o;
                dat_seen = dat_o;
                adr_seen = adr_o;
            end
            if (rsp_valid_o) begin
                lat   = i;
                rdata = rsp_rdata_o;
                err   = rsp_err_o;
                break;
            end
        end
        @(posedge clk_i); #1;
    endtask

    logic [31:0] rd, sd, ad;
    logic [3:0]  sl;
    logic        er, sc;
    int          lt;
    int          ncyc;
    int          npulse;

    initial begin
        checks = 0; failures = 0;
        rst_ni = 1'b0; ack_auto = 1'b1; ack_man = 1'b0;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00; req_unsigned_i = 1'b0;
        req_addr_i = 32'h0; req_wdata_i = 32'h0; dat_i = 32'h80FF7F01;

        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_cyc", {31'h0, cyc_o}, 32'h0);
        chk("rst_rsp", {30'h0, rsp_valid_o, rsp_err_o}, 32'h0);
        chk("rst_bus", adr_o | dat_o | {28'h0, sel_o} | {31'h0, we_o}, 32'h0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("rst_ready", {31'h0, req_ready_o}, 32'h1);

        // SB 0xA5 at 0x103
        do_req(1'b1, 2'b00, 1'b0, 32'h103, 32'h000000A5, rd, er, lt, sc, sl, sd, ad);
        chk("sb_sel", {28'h0, sl}, 32'h8);
        chk("sb_dat", sd, 32'hA5A5A5A5);
        chk("sb_adr", ad, 32'h100);
        chk("sb_lat", lt, 32'd2);
        chk("sb_err", {31'h0, er}, 32'h0);

        // Loads against memory word 0x80FF7F01
        do_req(1'b0, 2'b00, 1'b0, 32'h102, 32'h0, rd, er, lt, sc, sl, sd, ad);
        chk("lb_data", rd, 32'hFFFFFFFF);
        chk("lb_lat", lt, 32'd3);
        chk("lb_sel", {28'h0, sl}, 32'h4);
        do_req(1'b0, 2'b00, 1'b1, 32'h102, 32'h0, rd, er, lt, sc, sl, sd, ad);
        chk("lbu_data", rd, 32'h000000FF);
        do_req(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, rd, er, lt, sc, sl, sd, ad);
        chk("lh_data", rd, 32'hFFFF80FF);
        chk("lh_sel", {28'h0, sl}, 32'hC);
        do_req(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, rd, er, lt, sc, sl, sd, ad);
        chk("lhu_lo_data", rd, 32'h00007F01);
        do_req(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, rd, er, lt, sc, sl, sd, ad);
        chk("lw_data", rd, 32'h80FF7F01);
        chk("lw_adr", ad, 32'h104);

        // SH at 0x102
        do_req(1'b1, 2'b01, 1'b0, 32'h102, 32'h1234BEEF, rd, er, lt, sc, sl, sd, ad);
        chk("sh_sel", {28'h0, sl}, 32'hC);
        chk("sh_dat", sd, 32'hBEEFBEEF);
        chk("sh_rdata", rd, 32'h0);

        // Misaligned word and illegal size: no bus cycle, error response
        do_req(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, rd, er, lt, sc, sl, sd, ad);
        chk("lwmis_cyc", {31'h0, sc}, 32'h0);
        chk("lwmis_err", {31'h0, er}, 32'h1);
        chk("lwmis_rdata", rd, 32'h0);
        chk("lwmis_lat", lt, 32'd1);
        do_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, rd, er, lt, sc, sl, sd, ad);
        chk("ill_cyc", {31'h0, sc}, 32'h0);
        chk("ill_err", {31'h0, er}, 32'h1);
        do_req(1'b1, 2'b01, 1'b0, 32'h101, 32'h0, rd, er, lt, sc, sl, sd, ad);
        chk("shmis_err", {30'h0, sc, er}, 32'h1);

        // Stray ack while idle is ignored
        ack_man = 1'b1;
        @(posedge clk_i); #1;
        ack_man = 1'b0;
        chk("stray_ack", {30'h0, rsp_valid_o, req_ready_o}, 32'h1);

        // Slave holds off ack for 5 bus cycles
        ack_auto = 1'b0;
        req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'b10; req_unsigned_i = 1'b0;
        req_addr_i = 32'h200; req_wdata_i = 32'h12345678;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("wait_bus", {cyc_o, stb_o, we_o, rsp_valid_o, sel_o, adr_o[23:0]},
                {4'b1110, 4'hF, 24'h000200});
            chk("wait_dat", dat_o, 32'h12345678);
            @(posedge clk_i); #1;
        end
        ack_man = 1'b1;
        @(posedge clk_i); #1;
        ack_man = 1'b0;
        npulse = 0;
        for (int k = 0; k < 4; k++) begin
            if (rsp_valid_o) npulse++;
            @(posedge clk_i); #1;
        end
        chk("wait_pulses", npulse, 32'd1);

`ifdef WB_LSU_TIMEOUT_EN
        // Slave never answers: the master gives up after 16 bus cycles
        req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'b10; req_addr_i = 32'h400;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        ncyc = 0;
        for (int k = 0; k < 40 && cyc_o; k++) begin
            ncyc++;
            @(posedge clk_i); #1;
        end
        chk("tmo_cycles", ncyc, 32'd16);
        chk("tmo_rsp", {30'h0, rsp_valid_o, rsp_err_o}, 32'h3);
        chk("tmo_rdata", rsp_rdata_o, 32'h0);
        @(posedge clk_i); #1;
`else
        // Without the timeout the bus cycle simply waits
        req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'b10; req_addr_i = 32'h400;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        ncyc = 0;
        for (int k = 0; k < 20; k++) begin
            if (cyc_o) ncyc++;
            @(posedge clk_i); #1;
        end
        chk("notmo_cycles", ncyc, 32'd20);
        ack_man = 1'b1;
        @(posedge clk_i); #1;
        ack_man = 1'b0;
        @(posedge clk_i); #1;
        chk("notmo_rsp", {30'h0, rsp_valid_o, rsp_err_o}, 32'h2);
        chk("notmo_rdata", rsp_rdata_o, 32'h80FF7F01);
        @(posedge clk_i); #1;
`endif

        // Reset in the middle of a bus cycle
        req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'b10; req_addr_i = 32'h300;
        req_wdata_i = 32'hCAFEF00D;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        chk("mid_cyc_pre", {31'h0, cyc_o}, 32'h1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mid_cyc_rst", {30'h0, cyc_o, stb_o}, 32'h0);
        chk("mid_bus_rst", adr_o | dat_o | {28'h0, sel_o}, 32'h0);
        npulse = 0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk_i); #1;
            if (rsp_valid_o) npulse++;
        end
        rst_ni = 1'b1;
        ack_auto = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i); #1;
            if (rsp_valid_o) npulse++;
        end
        chk("mid_no_rsp", npulse, 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd, er, lt, sc, sl, sd, ad);
        chk("post_rst_data", rd, 32'h80FF7F01);
        chk("post_rst_lat", lt, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
